vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates the raster timing for the 80x25 text path at 720x400, 70 Hz.
- Produces `active`, `eol` and a pixel/line position for the text driver. The text driver uses these to step its 9-pixel character columns, count scanlines and prefetch the next row between lines.
- Produces `hsync`/`vsync` to the DAC/connector. These are delayed by a configurable number of stages so they line up with the text driver's colour output latency.
- Also produces a frame-end pulse and a free-running frame counter, which drives cursor blink and software vsync polling.

Parameters:
- H_ACTIVE, 720, visible pixels per line
- H_FP, 18, horizontal front porch (pixels)
- H_SYNC, 108, horizontal sync width (pixels)
- H_BP, 54, horizontal back porch (pixels)
- V_ACTIVE, 400, visible lines per frame
- V_FP, 12, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 35, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 1, vsync asserted level (1 = active-high)
- SYNC_DELAY, 2, register stages on hsync_o/vsync_o relative to active_o (0..15; 0 = no delay)

Ports:
- clk_i  in  1  pixel (dot) clock
- rst_ni  in  1  reset, asynchronous assert, active-low
- en_i  in  1  timing enable; low holds the raster at origin, blanked
- active_o  out  1  current pixel is inside the visible area
- eol_o  out  1  one-cycle pulse on the last visible pixel of each visible line
- eof_o  out  1  one-cycle pulse on the last pixel of the frame
- x_o  out  12  horizontal count, 0..H_TOTAL-1
- y_o  out  12  vertical count, 0..V_TOTAL-1
- hsync_o  out  1  horizontal sync, polarity HS_POL, delayed SYNC_DELAY cycles
- vsync_o  out  1  vertical sync, polarity VS_POL, delayed SYNC_DELAY cycles
- frame_o  out  8  frame counter

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 900).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 449).
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Values while rst_ni is low:
  - x_o = 0, y_o = 0, frame_o = 0.
  - active_o = 0, eol_o = 0, eof_o = 0.
  - hsync_o = ~HS_POL, vsync_o = ~VS_POL, and every sync delay stage holds the inactive level.
- States:
  - IDLE: en_i low, or the first cycle after reset release.
  - RUN.
- IDLE:
  - x = y = 0; active/eol/eof = 0.
  - Sync pipeline inputs held inactive.
  - frame_o is held, not cleared.
- IDLE -> RUN: on a clock edge with en_i = 1. The first RUN cycle presents x = 0, y = 0, active_o = 1.
- RUN -> IDLE: on any clock edge with en_i = 0, including mid-line or mid-frame. The next cycle shows IDLE values, and no eol/eof pulse is emitted for the truncated line.
- Counting in RUN:
  - x increments every cycle; it wraps from H_TOTAL-1 to 0.
  - y increments when x wraps; it wraps from V_TOTAL-1 to 0 on the same edge.
- Decodes (all registered, coincident with the x_o/y_o they describe):
  - active_o = (x < H_ACTIVE) && (y < V_ACTIVE).
  - eol_o = (x == H_ACTIVE-1) && (y < V_ACTIVE). This is exactly the last cycle of active_o on each visible line; the following cycle has active_o = 0.
  - eof_o = (x == H_TOTAL-1) && (y == V_TOTAL-1).
  - hsync asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, every line including vertical blanking.
  - vsync asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for all x on those lines.
- Sync delay:
  - The undelayed decodes feed a SYNC_DELAY-deep shift register; the output is the last stage.
  - SYNC_DELAY = 0 connects the decodes directly.
  - The pipeline keeps shifting in IDLE (inactive values), so syncs drain cleanly after en_i falls.
- frame_o: increments by 1 in the cycle after eof_o, modulo 256 (255 -> 0).
- x_o/y_o widths: 12 bits. Parameters must satisfy H_TOTAL <= 4096 and V_TOTAL <= 4096; an elaboration-time assertion fires otherwise.
- No combinational path from en_i to any output.

Test Plan:
- Reset and enable start: hold rst_ni low 5 cycles with en_i = 1 -> all outputs at reset values, hsync_o = 1, vsync_o = 0. Release -> the first active_o = 1 cycle has x_o = 0, y_o = 0.
- Line timing (defaults): count cycles over 3 lines -> active_o high 720 cycles per line, eol_o exactly once per line at x_o = 719, line period 900. hsync_o low for 108 cycles starting at x = 738+2 (SYNC_DELAY = 2).
- Frame timing: run 2 full frames -> 400 eol_o pulses per frame, eof_o at x = 899, y = 448, frame period 404100 cycles. vsync_o high for 1800 cycles beginning at y = 412. frame_o goes 0 -> 1 -> 2.
- Mid-frame disable: drop en_i at x = 300, y = 200 for 10 cycles -> next cycle x = y = 0 and active_o = 0, no eol/eof. Syncs go inactive after 2 cycles, frame_o unchanged. Re-enable restarts at (0,0).
- Async reset mid-line: assert rst_ni between clock edges at x = 500 -> outputs reach reset values without waiting for a clock edge. frame_o = 0 after release.
- Parameter variant: SYNC_DELAY = 0, HS_POL = 1, H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48 -> hsync_o high at x = 656..751, coincident with x_o. Line period 800.

Source files
------------

// File: rtl/vga_timing.sv
// Raster timing generator for the 720x400 @ 70 Hz text path: pixel/line position,
// blanking decodes, latency-matched sync outputs and a free-running frame counter.
module vga_timing #(
    parameter int H_ACTIVE   = 720,
    parameter int H_FP       = 18,
    parameter int H_SYNC     = 108,
    parameter int H_BP       = 54,
    parameter int V_ACTIVE   = 400,
    parameter int V_FP       = 12,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 35,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b1,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic        active_o,
    output logic        eol_o,
    output logic        eof_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [7:0]  frame_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_delay
        $error("vga_timing: SYNC_DELAY must be in 0..15");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [11:0] x_nxt;
    logic [11:0] y_nxt;
    logic        hs_raw;
    logic        vs_raw;

    // Position the registers will hold next; leaving IDLE always restarts at the origin.
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        x_nxt = '0;
        y_nxt = '0;
        if (state == RUN) begin
            if (int'(x_o) == H_TOTAL - 1) begin
                y_nxt = (int'(y_o) == V_TOTAL - 1) ? '0 : y_o + 12'd1;
            end else begin
                x_nxt = x_o + 12'd1;
                y_nxt = y_o;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            x_o      <= '0;
            y_o      <= '0;
            active_o <= 1'b0;
            eol_o    <= 1'b0;
            eof_o    <= 1'b0;
            hs_raw   <= ~HS_POL;
            vs_raw   <= ~VS_POL;
            frame_o  <= '0;
        end else begin
            frame_o <= frame_o + {7'd0, eof_o};
            if (en_i) begin
                state    <= RUN;
                x_o      <= x_nxt;
                y_o      <= y_nxt;
                active_o <= (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
                eol_o    <= (int'(x_nxt) == H_ACTIVE - 1) && (int'(y_nxt) < V_ACTIVE);
                eof_o    <= (int'(x_nxt) == H_TOTAL - 1) && (int'(y_nxt) == V_TOTAL - 1);
                hs_raw   <= (int'(x_nxt) >= HS_START && int'(x_nxt) < HS_END) ? HS_POL : ~HS_POL;
                vs_raw   <= (int'(y_nxt) >= VS_START && int'(y_nxt) < VS_END) ? VS_POL : ~VS_POL;
            end else begin
                state    <= IDLE;
                x_o      <= '0;
                y_o      <= '0;
                active_o <= 1'b0;
                eol_o    <= 1'b0;
                eof_o    <= 1'b0;
                hs_raw   <= ~HS_POL;
                vs_raw   <= ~VS_POL;
            end
        end
    end

    // Sync delay line matching the text driver's colour latency; it shifts even while idle.
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hsync_o = hs_raw;
        assign vsync_o = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe;
        logic [SYNC_DELAY-1:0] vs_pipe;

        // NOTE: this shift register is reset (unlike a data memory) because it drives the connector.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hs_pipe <= {SYNC_DELAY{~HS_POL}};
                vs_pipe <= {SYNC_DELAY{~VS_POL}};
            end else begin
                hs_pipe <= SYNC_DELAY'({hs_pipe, hs_raw});
                vs_pipe <= SYNC_DELAY'({vs_pipe, vs_raw});
            end
        end

        assign hsync_o = hs_pipe[SYNC_DELAY-1];
        assign vsync_o = vs_pipe[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: two configurations driven with randomized enable gaps,
// checked every cycle against a raster model built from elapsed run time.
module tb_vga_timing;

    typedef struct packed {
        int h_act; int h_fp; int h_sync; int h_bp;
        int v_act; int v_fp; int v_sync; int v_bp;
        bit hs_pol; bit vs_pol; int dly;
    } cfg_t;

    typedef struct packed {
        logic        active;
        logic        eol;
        logic        eof;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  frame;
    } obs_t;

    // Default horizontal timing with a short frame so whole frames fit the cycle budget.
    localparam cfg_t CFG_A = '{h_act: 720, h_fp: 18, h_sync: 108, h_bp: 54,
                               v_act: 8, v_fp: 2, v_sync: 2, v_bp: 3,
                               hs_pol: 1'b0, vs_pol: 1'b1, dly: 2};
    localparam cfg_t CFG_B = '{h_act: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                               v_act: 6, v_fp: 1, v_sync: 2, v_bp: 2,
                               hs_pol: 1'b1, vs_pol: 1'b1, dly: 0};
    localparam int FRAME_A = 900 * 15;

    bit clk;
    logic rst_n;
    logic en;

    logic a_active, a_eol, a_eof, a_hs, a_vs;
    logic [11:0] a_x, a_y;
    logic [7:0] a_frame;
    logic b_active, b_eol, b_eof, b_hs, b_vs;
    logic [11:0] b_x, b_y;
    logic [7:0] b_frame;

    obs_t got_a, got_b;
    assign got_a = {a_active, a_eol, a_eof, a_hs, a_vs, a_x, a_y, a_frame};
    assign got_b = {b_active, b_eol, b_eof, b_hs, b_vs, b_x, b_y, b_frame};

    vga_timing #(
        .H_ACTIVE(CFG_A.h_act), .H_FP(CFG_A.h_fp), .H_SYNC(CFG_A.h_sync), .H_BP(CFG_A.h_bp),
        .V_ACTIVE(CFG_A.v_act), .V_FP(CFG_A.v_fp), .V_SYNC(CFG_A.v_sync), .V_BP(CFG_A.v_bp),
        .HS_POL(CFG_A.hs_pol), .VS_POL(CFG_A.vs_pol), .SYNC_DELAY(CFG_A.dly)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .active_o(a_active), .eol_o(a_eol), .eof_o(a_eof), .x_o(a_x), .y_o(a_y),
        .hsync_o(a_hs), .vsync_o(a_vs), .frame_o(a_frame)
    );

    vga_timing #(
        .H_ACTIVE(CFG_B.h_act), .H_FP(CFG_B.h_fp), .H_SYNC(CFG_B.h_sync), .H_BP(CFG_B.h_bp),
        .V_ACTIVE(CFG_B.v_act), .V_FP(CFG_B.v_fp), .V_SYNC(CFG_B.v_sync), .V_BP(CFG_B.v_bp),
        .HS_POL(CFG_B.hs_pol), .VS_POL(CFG_B.vs_pol), .SYNC_DELAY(CFG_B.dly)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .active_o(b_active), .eol_o(b_eol), .eof_o(b_eof), .x_o(b_x), .y_o(b_y),
        .hsync_o(b_hs), .vsync_o(b_vs), .frame_o(b_frame)
    );

    initial forever #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    int   t_run [2];
    int   frame_m [2];
    bit   prev_eof [2];
    bit   hs_hist [2][$];
    bit   vs_hist [2][$];
    obs_t expq [2][$];
    obs_t last [2];
    obs_t exp_a, exp_b;

    function automatic cfg_t cfg_of(input int i);
        return (i == 0) ? CFG_A : CFG_B;
    endfunction

    function automatic obs_t model_reset(input int i);
        cfg_t c = cfg_of(i);
        obs_t o;
        t_run[i] = -1;
        frame_m[i] = 0;
        prev_eof[i] = 1'b0;
        hs_hist[i].delete();
        vs_hist[i].delete();
        for (int k = 0; k < c.dly; k++) begin
            hs_hist[i].push_back(~c.hs_pol);
            vs_hist[i].push_back(~c.vs_pol);
        end
        o = '0;
        o.hs = ~c.hs_pol;
        o.vs = ~c.vs_pol;
        return o;
    endfunction

    // Position is derived from the number of cycles spent running since the last restart.
    function automatic obs_t model_edge(input int i, input bit e);
        cfg_t c = cfg_of(i);
        int htot = c.h_act + c.h_fp + c.h_sync + c.h_bp;
        int vtot = c.v_act + c.v_fp + c.v_sync + c.v_bp;
        int xx = 0;
        int yy = 0;
        bit hs_raw = ~c.hs_pol;
        bit vs_raw = ~c.vs_pol;
        obs_t o = '0;
        if (prev_eof[i]) frame_m[i] = (frame_m[i] + 1) % 256;
        t_run[i] = e ? ((t_run[i] < 0) ? 0 : t_run[i] + 1) : -1;
        if (t_run[i] >= 0) begin
            xx = t_run[i] % htot;
            yy = (t_run[i] / htot) % vtot;
            o.active = (xx < c.h_act) && (yy < c.v_act);
            o.eol    = (xx == c.h_act - 1) && (yy < c.v_act);
            o.eof    = (xx == htot - 1) && (yy == vtot - 1);
            if (xx >= c.h_act + c.h_fp && xx < c.h_act + c.h_fp + c.h_sync) hs_raw = c.hs_pol;
            if (yy >= c.v_act + c.v_fp && yy < c.v_act + c.v_fp + c.v_sync) vs_raw = c.vs_pol;
        end
        prev_eof[i] = o.eof;
        hs_hist[i].push_back(hs_raw);
        vs_hist[i].push_back(vs_raw);
        o.hs = hs_hist[i].pop_front();
        o.vs = vs_hist[i].pop_front();
        o.x = 12'(xx);
        o.y = 12'(yy);
        o.frame = 8'(frame_m[i]);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got act=%b eol=%b eof=%b hs=%b vs=%b x=%0d y=%0d frame=%0d, expected act=%b eol=%b eof=%b hs=%b vs=%b x=%0d y=%0d frame=%0d",
                     name, $time, got.active, got.eol, got.eof, got.hs, got.vs, got.x, got.y, got.frame,
                     exp.active, exp.eol, exp.eof, exp.hs, exp.vs, exp.x, exp.y, exp.frame);
        end
    endtask

    task automatic check_bound(input string name, input int got, input int limit);
        n_checks++;
        if (got >= limit) begin
            n_fail++;
            $display("FAIL %s: got %0d cycles, required fewer than %0d", name, got, limit);
        end
    endtask

    // Drive one enable value, advance one clock and queue the model's expectation for it.
    task automatic cycle(input bit e);
        en = e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) last[i] = model_reset(i);
            else        last[i] = model_edge(i, e);
            expq[i].push_back(last[i]);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (expq[0].size() > 0) begin
            exp_a = expq[0].pop_front();
            check("dut_a", got_a, exp_a);
        end
        if (expq[1].size() > 0) begin
            exp_b = expq[1].pop_front();
            check("dut_b", got_b, exp_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time %0t, required finish before 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 2; i++) last[i] = model_reset(i);

        repeat (5) cycle(1'b1);
        rst_n = 1'b1;

        repeat (2 * FRAME_A) cycle(1'b1);

        guard = 0;
        while (!(last[0].x == 12'd300 && last[0].y == 12'd5) && guard < 20000) begin
            cycle(1'b1);
            guard++;
        end
        check_bound("reach_x300_y5", guard, 20000);
        repeat (10) cycle(1'b0);
        repeat (3000) cycle(1'b1);

        repeat (10000) begin
            if ($urandom_range(0, 799) == 0) repeat ($urandom_range(1, 12)) cycle(1'b0);
            else cycle(1'b1);
        end

        guard = 0;
        while (!(last[0].x == 12'd500 && last[0].active) && guard < 20000) begin
            cycle(1'b1);
            guard++;
        end
        check_bound("reach_x500", guard, 20000);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            void'(expq[i].pop_back());
            last[i] = model_reset(i);
            expq[i].push_back(last[i]);
        end
        repeat (3) cycle(1'b1);
        rst_n = 1'b1;
        repeat (2000) cycle(1'b1);

        @(negedge clk);
        #1;
        check_bound("scoreboard_drain", expq[0].size() + expq[1].size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
